// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline control stage.
package pipe_pkg;

    // Halt/resume FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN    = 2'd0;
    localparam state_t ST_HALT   = 2'd1;
    localparam state_t ST_RESUME = 2'd2;

    // EX operand forward selects
    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_JAL = 2'd3;

    // Pipeline enable/flush bundle
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
    } ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-detector to pipeline-control bundle.
// Counter signals exist only when PIPE_HAZARD_STATS_EN is defined.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
    logic       Load_use;
    logic [1:0] Forward_R1;
    logic [1:0] Forward_R2;
    logic       Branch_EX;
    logic       Jump_ID;
    logic       Halt_ID;
    logic       Go;
    logic       PC_en;
    logic       IFID_en;
    logic       IFID_flush;
    logic       IDEX_flush;
    logic [1:0] Forward_R1_EX;
    logic [1:0] Forward_R2_EX;
    logic       Halted;
`ifdef PIPE_HAZARD_STATS_EN
    logic [CNT_W-1:0] Cycle_cnt;
    logic [CNT_W-1:0] Stall_cnt;
    logic [CNT_W-1:0] Flush_cnt;
`endif

    // Upstream side: ID-stage detector plus the Go button
    modport master (
        output Load_use, Forward_R1, Forward_R2, Branch_EX, Jump_ID, Halt_ID, Go,
        input  PC_en, IFID_en, IFID_flush, IDEX_flush, Forward_R1_EX, Forward_R2_EX, Halted
`ifdef PIPE_HAZARD_STATS_EN
      , input  Cycle_cnt, Stall_cnt, Flush_cnt
`endif
    );

    // Control block side
    modport slave (
        input  Load_use, Forward_R1, Forward_R2, Branch_EX, Jump_ID, Halt_ID, Go,
        output PC_en, IFID_en, IFID_flush, IDEX_flush, Forward_R1_EX, Forward_R2_EX, Halted
`ifdef PIPE_HAZARD_STATS_EN
      , output Cycle_cnt, Stall_cnt, Flush_cnt
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sync_edge.sv
// 2-FF synchronizer plus rising-edge detector for the asynchronous Go button.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);
    logic r_s1, r_s2, r_prev;

    // Synchronize, then keep the previous synchronized value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_prev;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control stage: PC/IF-ID enables, IF-ID/ID-EX flushes, registered
// forward selects and the syscall halt/resume FSM.
// Optional statistics counters: define PIPE_HAZARD_STATS_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    state_t     r_state;
    state_t     w_state_nxt;
    ctl_t       w_ctl;
    logic       w_go_rise;
    logic [1:0] r_fwd1, r_fwd2;

    sync_edge u_go_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.Go),
        .o_rise  (w_go_rise)
    );

    // Control decode; a taken branch squashes everything younger, so it wins
    always_comb begin
        w_ctl       = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
        w_state_nxt = r_state;
        if (r_state == ST_HALT) begin
            w_ctl = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
            if (w_go_rise)
                w_state_nxt = ST_RESUME;
        end else begin
            if (r_state == ST_RESUME)
                w_state_nxt = ST_RUN;
            if (bus.Branch_EX) begin
                w_ctl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
            end else if (bus.Load_use) begin
                w_ctl = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
            end else if (bus.Halt_ID && r_state == ST_RUN) begin
                // halt in RESUME is the held instruction itself, let it pass
                w_ctl       = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
                w_state_nxt = ST_HALT;
            end else if (bus.Jump_ID) begin
                w_ctl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Forward selects into EX; a bubble must not forward anything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd1 <= FWD_REG;
            r_fwd2 <= FWD_REG;
        end else if (w_ctl.idex_flush) begin
            r_fwd1 <= FWD_REG;
            r_fwd2 <= FWD_REG;
        end else begin
            r_fwd1 <= bus.Forward_R1;
            r_fwd2 <= bus.Forward_R2;
        end
    end

    assign bus.PC_en         = w_ctl.pc_en;
    assign bus.IFID_en       = w_ctl.ifid_en;
    assign bus.IFID_flush    = w_ctl.ifid_flush;
    assign bus.IDEX_flush    = w_ctl.idex_flush;
    assign bus.Forward_R1_EX = r_fwd1;
    assign bus.Forward_R2_EX = r_fwd2;
    assign bus.Halted        = (r_state == ST_HALT);

`ifdef PIPE_HAZARD_STATS_EN
    logic [CNT_W-1:0] r_cyc, r_stall, r_flush;
    logic             w_active;

    assign w_active = (r_state != ST_HALT);

    // Saturating statistics counters for the board display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc   <= '0;
            r_stall <= '0;
            r_flush <= '0;
        end else if (w_active) begin
            if (r_cyc != '1)
                r_cyc <= r_cyc + 1'b1;
            if (bus.Load_use && !bus.Branch_EX && r_stall != '1)
                r_stall <= r_stall + 1'b1;
            if (bus.Branch_EX && r_flush != '1)
                r_flush <= r_flush + 1'b1;
        end
    end

    assign bus.Cycle_cnt = r_cyc;
    assign bus.Stall_cnt = r_stall;
    assign bus.Flush_cnt = r_flush;
`endif
endmodule
